// File: rtl/tdes_ahb_master.sv
// rtl/tdes_ahb_master.sv - AHB-Lite master sequencing the Triple-DES slave register map
module tdes_ahb_master #(
  parameter int SLOT_CYCLES = 8,
  parameter int LAT_SLOTS   = 6,
  parameter int READ_OFFSET = 5
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        enc_dec,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        err,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [63:0] HWDATA,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK
);

  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int OW = $clog2(LAT_SLOTS + 2);
  localparam logic [SW-1:0] LAST_CYC = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] RD_CYC   = SW'(READ_OFFSET);
  localparam logic [SW-1:0] CAP_CYC  = SW'(READ_OFFSET + 1);
  localparam logic [SW-1:0] CFG_END  = SW'(4);
  localparam logic [OW-1:0] LAT      = OW'(LAT_SLOTS);
  localparam logic [31:0] A_MODE  = 32'hAAAAAAA0;
  localparam logic [31:0] A_CHUNK = 32'hAAAAAAA4;
  localparam logic [31:0] A_RES   = 32'hAAAAAAA8;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {IDLE, CFG, SLOT_WAIT, SLOT, DRAIN, ERROR} state_t;

  state_t        state, stateNext;
  logic [SW-1:0] slotCnt, slotCntNext;
  logic [OW-1:0] outCnt, outCntNext;
  logic          readSlot, readSlotNext;
  logic          modeReg, lastReg, dataPhase, errReg, accept;
  logic [63:0]   key1Reg, key2Reg, key3Reg, chunkReg;
  logic          wrData, rdData, errHit, advance;

  assign HSIZE     = 3'b011;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'h3;
  assign HMASTLOCK = 1'b0;
  assign err       = errReg;
  assign busy      = (state == CFG) || (state == SLOT_WAIT) || (state == SLOT) || (state == DRAIN);

  // Chunk write data phase is slot cycle 1; result data phase follows the read address cycle.
  assign wrData  = (state == SLOT) && (slotCnt == SW'(1));
  assign rdData  = ((state == SLOT) || (state == DRAIN)) && readSlot && (slotCnt == CAP_CYC);
  // An error response aborts everything regardless of HREADY.
  assign errHit  = dataPhase && HRESP;
  assign advance = HREADY || (state == IDLE) || (state == ERROR);

  // Outstanding-chunk count after this cycle's write and read data phases.
  always_comb begin
    outCntNext = outCnt;
    if (wrData && !rdData) outCntNext = outCnt + 1'b1;
    else if (rdData && !wrData) outCntNext = outCnt - 1'b1;
  end

  // Next state and bus drive decoded from state and slot position.
  always_comb begin
    stateNext    = state;
    slotCntNext  = slotCnt;
    readSlotNext = readSlot;
    accept       = 1'b0;
    HSEL         = 1'b0;
    HADDR        = '0;
    HWRITE       = 1'b0;
    HTRANS       = TR_IDLE;
    HWDATA       = '0;
    in_ready     = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (start) begin
          stateNext   = CFG;
          slotCntNext = '0;
        end
      end
      CFG: begin
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        if (slotCnt < CFG_END) begin
          HTRANS = TR_NONSEQ;
          HADDR  = {A_MODE[31:2], slotCnt[1:0]};
        end
        if (slotCnt == SW'(1)) HWDATA = {63'b0, modeReg};
        else if (slotCnt == SW'(2)) HWDATA = key1Reg;
        else if (slotCnt == SW'(3)) HWDATA = key2Reg;
        else if (slotCnt == CFG_END) HWDATA = key3Reg;
        if (slotCnt == CFG_END) begin
          stateNext   = SLOT_WAIT;
          slotCntNext = '0;
        end else begin
          slotCntNext = slotCnt + 1'b1;
        end
      end
      SLOT_WAIT: begin
        HSEL     = 1'b1;
        HWRITE   = 1'b1;
        in_ready = HREADY;
        // The handshake cycle doubles as slot cycle 0 so back-to-back chunks keep the slot rate.
        if (in_valid && HREADY) begin
          accept       = 1'b1;
          HTRANS       = TR_NONSEQ;
          HADDR        = A_CHUNK;
          stateNext    = SLOT;
          slotCntNext  = SW'(1);
          readSlotNext = (outCnt >= LAT);
        end
      end
      SLOT, DRAIN: begin
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        if (wrData) HWDATA = chunkReg;
        if (readSlot && (slotCnt == RD_CYC)) begin
          HADDR  = A_RES;
          HWRITE = 1'b0;
          HTRANS = TR_NONSEQ;
        end
        if (slotCnt == LAST_CYC) begin
          slotCntNext = '0;
          if ((state == DRAIN) || lastReg) begin
            if (outCntNext == '0) begin
              stateNext = IDLE;
            end else begin
              stateNext    = DRAIN;
              readSlotNext = 1'b1;
            end
          end else begin
            stateNext = SLOT_WAIT;
          end
        end else begin
          slotCntNext = slotCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control state; everything holds while the slave stretches a phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      slotCnt   <= '0;
      outCnt    <= '0;
      readSlot  <= 1'b0;
      dataPhase <= 1'b0;
      errReg    <= 1'b0;
      modeReg   <= 1'b0;
      key1Reg   <= '0;
      key2Reg   <= '0;
      key3Reg   <= '0;
      chunkReg  <= '0;
      lastReg   <= 1'b0;
    end else if (errHit) begin
      state     <= ERROR;
      slotCnt   <= '0;
      outCnt    <= '0;
      readSlot  <= 1'b0;
      dataPhase <= 1'b0;
      errReg    <= 1'b1;
    end else if (advance) begin
      state     <= stateNext;
      slotCnt   <= slotCntNext;
      outCnt    <= outCntNext;
      readSlot  <= readSlotNext;
      dataPhase <= (HTRANS == TR_NONSEQ);
      if (((state == IDLE) || (state == ERROR)) && start) begin
        modeReg <= enc_dec;
        key1Reg <= key1;
        key2Reg <= key2;
        key3Reg <= key3;
        errReg  <= 1'b0;
      end
      if (accept) begin
        chunkReg <= in_data;
        lastReg  <= in_last;
      end
    end
  end

  // Result capture when the read data phase completes without error.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= rdData && HREADY && !errHit;
      if (rdData && HREADY && !errHit) out_data <= HRDATA;
    end
  end

endmodule

// File: tb/tb_tdes_ahb_master.sv
// tb/tb_tdes_ahb_master.sv - scoreboard bench for tdes_ahb_master against a behavioural slave
module tb_tdes_ahb_master;

  localparam logic [31:0] A_MODE  = 32'hAAAAAAA0;
  localparam logic [31:0] A_K1    = 32'hAAAAAAA1;
  localparam logic [31:0] A_K2    = 32'hAAAAAAA2;
  localparam logic [31:0] A_K3    = 32'hAAAAAAA3;
  localparam logic [31:0] A_CHUNK = 32'hAAAAAAA4;
  localparam logic [31:0] A_RES   = 32'hAAAAAAA8;
  localparam logic [63:0] RMASK   = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] K1      = 64'h6b776c6f70617772;
  localparam logic [63:0] K2      = 64'h64736B65776A7272;
  localparam logic [63:0] K3      = 64'h736865726c6f636b;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0, enc_dec = 1'b0;
  logic [63:0] key1 = '0, key2 = '0, key3 = '0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, out_valid, busy, err;
  logic [63:0] out_data;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic [63:0] HRDATA = '0;
  logic        HSEL, HWRITE, HMASTLOCK;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [63:0] HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int total = 0, bad = 0, cyc = 0;
  int nonseqCnt = 0, outCount = 0, lastOvCyc = 0, stallLeft = 0;
  logic errArm = 1'b0;
  logic dp = 1'b0, dpWrite = 1'b0;
  logic [31:0] dpAddr = '0;
  logic [63:0] sbq[$], wrExp[$], slvFifo[$];
  int a4Cyc[$], a8Cyc[$];

  tdes_ahb_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .enc_dec(enc_dec),
    .key1(key1), .key2(key2), .key3(key3),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .err(err),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave: drives response at negedge, samples bus two units later.
  initial forever begin
    @(negedge HCLK);
    cyc++;
    if (HRESET) begin
      dp = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    end else begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      if (dp) begin
        if (dpWrite && dpAddr == A_CHUNK && stallLeft > 0) begin HREADY = 1'b0; stallLeft--; end
        if (dpWrite && dpAddr == A_K2 && errArm) begin HRESP = 1'b1; errArm = 1'b0; end
        if (!dpWrite && slvFifo.size() > 0) HRDATA = slvFifo[0] ^ RMASK;
      end
      #2;
      if (out_valid) begin
        outCount++;
        lastOvCyc = cyc;
        if (sbq.size() == 0) checkVal("ovExtra", 1, 0);
        else checkVal("outData", out_data, sbq.pop_front());
      end
      if (dp && HREADY) begin
        if (dpWrite && dpAddr == A_CHUNK) begin
          if (wrExp.size() > 0) checkVal("chunkWr", HWDATA, wrExp.pop_front());
          else checkVal("chunkWrExtra", 1, 0);
          slvFifo.push_back(HWDATA);
        end
        if (!dpWrite && slvFifo.size() > 0) void'(slvFifo.pop_front());
      end else if (dp && dpWrite && dpAddr == A_CHUNK && wrExp.size() > 0) begin
        checkVal("stallWdata", HWDATA, wrExp[0]);
      end
      if (HREADY) begin
        dp = HSEL && (HTRANS == 2'b10);
        dpAddr = HADDR;
        dpWrite = HWRITE;
        if (dp) begin
          nonseqCnt++;
          if (HADDR == A_CHUNK) a4Cyc.push_back(cyc);
          if (HADDR == A_RES) a8Cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic doStart(input logic mode);
    start = 1'b1; enc_dec = mode; key1 = K1; key2 = K2; key3 = K3;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    int n = 0;
    logic hs = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!hs && n < 300) begin
      @(negedge HCLK);
      #1;
      hs = in_ready;
      n++;
    end
    if (!hs) checkVal("sendTimeout", 0, 1);
    else begin
      sbq.push_back(d ^ RMASK);
      wrExp.push_back(d);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic waitIdle(output int fallCyc);
    int n = 0;
    do begin
      @(negedge HCLK);
      #3;
      n++;
    end while (busy && n < 600);
    if (busy) checkVal("idleTimeout", 0, 1);
    fallCyc = cyc;
  endtask

  initial begin
    int fall, snap, base;
    logic [63:0] d;

    repeat (3) tick();
    checkVal("rstHSEL", HSEL, 0);
    checkVal("rstHADDR", HADDR, 0);
    checkVal("rstHWRITE", HWRITE, 0);
    checkVal("rstHTRANS", HTRANS, 0);
    checkVal("rstHWDATA", HWDATA, 0);
    checkVal("rstInReady", in_ready, 0);
    checkVal("rstOutValid", out_valid, 0);
    checkVal("rstOutData", out_data, 0);
    checkVal("rstBusy", busy, 0);
    checkVal("rstErr", err, 0);
    HRESET = 1'b0;
    tick();

    doStart(1'b0);
    tick();
    #2 HRESET = 1'b1;
    #1;
    checkVal("midRstHSEL", HSEL, 0);
    checkVal("midRstHTRANS", HTRANS, 0);
    checkVal("midRstHADDR", HADDR, 0);
    checkVal("midRstHWDATA", HWDATA, 0);
    checkVal("midRstBusy", busy, 0);
    tick(); tick();
    HRESET = 1'b0;
    tick(); tick();
    checkVal("idleAfterRstBusy", busy, 0);
    checkVal("idleAfterRstHSEL", HSEL, 0);

    doStart(1'b0);
    checkVal("cfgA0", HADDR, A_MODE);
    checkVal("cfgT0", HTRANS, 2'b10);
    checkVal("cfgSel", HSEL, 1);
    tick();
    checkVal("cfgA1", HADDR, A_K1);
    checkVal("cfgWMode", HWDATA, 0);
    tick();
    checkVal("cfgA2", HADDR, A_K2);
    checkVal("cfgWK1", HWDATA, K1);
    tick();
    checkVal("cfgA3", HADDR, A_K3);
    checkVal("cfgWK2", HWDATA, K2);
    tick();
    checkVal("cfgT4", HTRANS, 0);
    checkVal("cfgWK3", HWDATA, K3);
    tick();
    checkVal("waitReady", in_ready, 1);

    a4Cyc.delete(); a8Cyc.delete(); outCount = 0;
    for (int i = 0; i < 10; i++) begin
      d = (i == 0) ? 64'h14fead4c23fe9280 : {$urandom, $urandom};
      send(d, i == 9);
    end
    waitIdle(fall);
    checkVal("aOuts", outCount, 10);
    checkVal("aSbEmpty", sbq.size(), 0);
    checkVal("aWrEmpty", wrExp.size(), 0);
    checkVal("aA4Count", a4Cyc.size(), 10);
    checkVal("aA8Count", a8Cyc.size(), 10);
    if (a4Cyc.size() == 10 && a8Cyc.size() == 10) begin
      checkVal("aSlot01", a4Cyc[1] - a4Cyc[0], 8);
      checkVal("aSlot89", a4Cyc[9] - a4Cyc[8], 8);
      checkVal("aFirstRead", a8Cyc[0] - a4Cyc[0], 53);
    end
    checkVal("aBusyFall", fall - lastOvCyc, 1);

    tick();
    doStart(1'b1);
    a4Cyc.delete(); a8Cyc.delete(); outCount = 0;
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 1'b0);
    repeat (10) tick();
    snap = nonseqCnt;
    repeat (20) tick();
    checkVal("gapBus", nonseqCnt - snap, 0);
    checkVal("gapCnt", dut.outCnt, 4);
    checkVal("gapReady", in_ready, 1);
    stallLeft = 3;
    send({$urandom, $urandom}, 1'b0);
    send({$urandom, $urandom}, 1'b0);
    send({$urandom, $urandom}, 1'b1);
    waitIdle(fall);
    checkVal("bOuts", outCount, 7);
    checkVal("bSbEmpty", sbq.size(), 0);
    checkVal("bStallUsed", stallLeft, 0);
    checkVal("bA4Count", a4Cyc.size(), 7);
    if (a4Cyc.size() == 7) checkVal("bStallShift", a4Cyc[5] - a4Cyc[4], 11);

    tick();
    errArm = 1'b1;
    base = outCount;
    doStart(1'b0);
    tick(); tick(); tick();
    tick();
    checkVal("errFlag", err, 1);
    checkVal("errHTRANS", HTRANS, 0);
    checkVal("errHSEL", HSEL, 0);
    checkVal("errBusy", busy, 0);
    repeat (5) tick();
    checkVal("errNoOut", outCount, base);
    checkVal("errSticky", err, 1);
    doStart(1'b1);
    checkVal("errClr", err, 0);
    checkVal("errRestartSel", HSEL, 1);
    checkVal("errRestartA0", HADDR, A_MODE);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/tdes_ahb_master.md
# tdes_ahb_master

AHB-Lite master that drives the Triple-DES slave's register map on behalf of a streaming client: it writes the mode bit and three keys, pushes 64-bit chunks at a fixed slot rate, and reads back completed chunks once the slave pipeline has filled. It sits between a local data source/sink and the TopLevel slave's AHB-Lite port. It replaces bench-driven bus sequencing with synthesizable control.

## Interface
- SLOT_CYCLES, 8: cycles per chunk slot (min 7).
- LAT_SLOTS, 6: chunks outstanding in the slave before the first result is readable.
- READ_OFFSET, 5: slot cycle in which the result-read address phase is issued (2..SLOT_CYCLES-2).
- HCLK  in  1  bus clock.
- HRESET  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse in IDLE; captures enc_dec, key1..key3.
- enc_dec  in  1  1 = encrypt, 0 = decrypt.
- key1, key2, key3  in  64 each  user keys.
- in_valid  in  1  chunk available.
- in_data  in  64  chunk.
- in_last  in  1  qualifies final chunk.
- in_ready  out  1  chunk accepted when in_valid & in_ready.
- out_valid  out  1  one-cycle pulse, result on out_data; no backpressure.
- out_data  out  64  result chunk.
- busy  out  1  high from start until drain complete.
- err  out  1  sticky error, cleared by start or reset.
- HREADY  in  1  slave ready; low stalls the current phase.
- HRESP  in  1  1 = ERROR response.
- HRDATA  in  64  read data.
- HSEL  out  1  slave select.
- HADDR  out  32  address.
- HWRITE  out  1  write enable.
- HTRANS  out  2  00 IDLE, 10 NONSEQ.
- HWDATA  out  64  write data.
- HSIZE, HBURST, HPROT, HMASTLOCK  out  3, 3, 4, 1  constants 3'b011, 3'b000, 4'h3, 0.

## Operation
- Register map: 0xAAAAAAA0 mode, A1 key1, A2 key2, A3 key3, A4 chunk, A8 result (read).
- States: IDLE, CFG, SLOT_WAIT, SLOT, DRAIN, ERROR.
- IDLE: HSEL=0, HTRANS=00, HADDR=0, HWDATA=0. start -> CFG, HSEL=1, err cleared.
- CFG, 5 cycles, pipelined. c0 addr A0; c1 addr A1, wdata {63'b0,enc_dec}; c2 addr A2, wdata key1; c3 addr A3, wdata key2; c4 addr 0/IDLE, wdata key3. Then SLOT_WAIT.
- SLOT_WAIT: in_ready=1. Handshake -> SLOT at cycle 0 in the same cycle: addr A4, HWRITE=1, NONSEQ.
- SLOT cycle 1: HWDATA=chunk, addr 0/IDLE. Other cycles: HWDATA=0.
- Read slot: outstanding count before this slot's write >= LAT_SLOTS, or DRAIN with outstanding > 0.
  - At READ_OFFSET: addr A8, HWRITE=0, NONSEQ.
  - At READ_OFFSET+1: HRDATA captured into out_data, out_valid pulses, HWRITE returns to 1.
- Outstanding counter: +1 per chunk write data phase, -1 per read. Simultaneous +/- leaves it unchanged. Max LAT_SLOTS+1.
- End of slot (cycle SLOT_CYCLES-1):
  - last chunk accepted or already in DRAIN -> DRAIN slot;
  - else -> SLOT_WAIT.
- DRAIN slots: no write, A4 never issued, read per slot until outstanding = 0, then IDLE, busy=0.
- HRESP=1 on any data phase -> ERROR:
  - HTRANS=IDLE, HSEL=0, err=1;
  - in-flight read not pulsed;
  - counter cleared;
  - start -> CFG.

## Timing
- Reset values: HSEL 0, HADDR 0, HWRITE 0, HTRANS 00, HWDATA 0, in_ready 0, out_valid 0, out_data 0, busy 0, err 0. State IDLE, counters 0.
- Async assert mid-transfer: outputs to reset values immediately; no partial completion.
- HREADY=0: all outputs, slot counter, and state hold; capture deferred until HREADY=1.
- First result: slot LAT_SLOTS, cycle READ_OFFSET+1 after chunk 0 slot start, with no stalls or gaps.
- Default throughput: 1 chunk per 8 cycles.
- start while busy: ignored.
- in_valid in CFG/SLOT/DRAIN: ignored; in_ready=0.

## Test plan
- Reset: HRESET=1 mid-CFG -> all outputs at reset values same cycle; state IDLE after release.
- Config: start, enc_dec=0, keys 6b776c6f70617772 / 64736B65776A7272 / 736865726c6f636b -> addr A0..A3 on cycles 0..3; wdata 0, key1, key2, key3 on cycles 1..4.
- Stream: 10 back-to-back chunks (first 14fead4c23fe9280, in_last on 10th).
  - Writes start 8 cycles apart.
  - First A8 read in slot 6, cycle 5.
  - Exactly 10 out_valid pulses, out_data = HRDATA from the model.
  - busy falls after the 10th read.
- Gap: in_valid low 20 cycles after chunk 3 -> SLOT_WAIT holds, no bus activity, counter stays 4.
- Stall: HREADY=0 for 3 cycles during chunk data phase -> HWDATA held, slot timing shifted by 3.
- Error: HRESP=1 on key2 data phase -> err=1, HTRANS IDLE next cycle, no out_valid; new start clears err.
